// File: rtl/lane_scan_renderer.sv
// Walks every square of every note lane once per frame, one draw request per square.
// Latency: first request valid the cycle after start; one request per cycle while ready is held.
// Backpressure: valid/ready; the request and all scan state hold while ready is low.
module lane_scan_renderer #(
  parameter int                       NUM_LANES     = 3,
  parameter int                       SQUARES       = 26,
  parameter int                       START_X       = 1,
  parameter int                       START_Y       = 53,
  parameter int                       X_OFFSET      = 5,
  parameter int                       Y_OFFSET      = 11,
  parameter logic [3*NUM_LANES-1:0]   LANE_COLOURS  = 9'b001_110_100,
  parameter int                       HIT_COL       = 0,
  parameter logic [2:0]               MARKER_COLOUR = 3'b111
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           clear_mode,
  input  logic [NUM_LANES*SQUARES-1:0]   lane_seq,
  output logic [7:0]                     out_x,
  output logic [6:0]                     out_y,
  output logic [2:0]                     colour,
  output logic                           valid,
  input  logic                           ready,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int NB = NUM_LANES * SQUARES;
  localparam int LW = $clog2(NUM_LANES + 1);
  localparam int SW = $clog2(SQUARES + 1);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [SW-1:0]   sq_q, sq_d;
  logic [NB-1:0]   seq_q, seq_d;
  logic            clr_q, clr_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      col_q, col_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Coordinates of the square to load next, and which note snapshot colours it.
  logic            load;
  int              nl, ns;
  logic [NB-1:0]   src_seq;
  logic            src_clr;

  // Wide intermediate so the wrap is a plain truncation, never a saturation.
  function automatic logic [7:0] calc_x(input int sq);
    int t;
    t = START_X + X_OFFSET * sq;
    return t[7:0];
  endfunction

  function automatic logic [6:0] calc_y(input int lane);
    int t;
    t = START_Y + Y_OFFSET * lane;
    return t[6:0];
  endfunction

  // Erase beats notes, notes beat the hit-zone marker, everything else is black.
  function automatic logic [2:0] calc_col(input logic [NB-1:0] seq, input logic clr,
                                          input int lane, input int sq);
    logic [2:0] c;
    c = 3'b000;
    if (!clr) begin
      if (seq[lane*SQUARES+sq])
        c = LANE_COLOURS[lane*3 +: 3];
      else if (sq == HIT_COL)
        c = MARKER_COLOUR;
    end
    return c;
  endfunction

  // Next-state, scan advance and request-register load.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    sq_d    = sq_q;
    seq_d   = seq_q;
    clr_d   = clr_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    nl      = int'(lane_q);
    ns      = int'(sq_q);
    src_seq = seq_q;
    src_clr = clr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // First square is coloured from the live inputs, which are the snapshot.
          seq_d   = lane_seq;
          clr_d   = clear_mode;
          src_seq = lane_seq;
          src_clr = clear_mode;
          lane_d  = '0;
          sq_d    = '0;
          nl      = 0;
          ns      = 0;
          load    = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ready) begin
          if (lane_q == LW'(NUM_LANES - 1) && sq_q == SW'(SQUARES - 1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (sq_q == SW'(SQUARES - 1)) begin
            sq_d   = '0;
            lane_d = lane_q + 1'b1;
            nl     = int'(lane_q) + 1;
            ns     = 0;
            load   = 1'b1;
          end else begin
            sq_d = sq_q + 1'b1;
            ns   = int'(sq_q) + 1;
            load = 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      x_d   = calc_x(ns);
      y_d   = calc_y(nl);
      col_d = calc_col(src_seq, src_clr, nl, ns);
    end
  end

  // State and request registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      lane_q  <= '0;
      sq_q    <= '0;
      seq_q   <= '0;
      clr_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      sq_q    <= sq_d;
      seq_q   <= seq_d;
      clr_q   <= clr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_x      = x_q;
  assign out_y      = y_q;
  assign colour     = col_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_lane_scan_renderer.sv
module tb_lane_scan_renderer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, clear_mode, ready;
  logic [77:0] lane_seq;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  colour;
  logic        valid, busy, frame_done;

  logic         start_b, ready_b;
  logic [239:0] lane_seq_b;
  logic [7:0]   out_x_b;
  logic [6:0]   out_y_b;
  logic [2:0]   colour_b;
  logic         valid_b, busy_b, frame_done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lane_scan_renderer dut (
    .clk(clk), .resetn(resetn), .start(start), .clear_mode(clear_mode),
    .lane_seq(lane_seq), .out_x(out_x), .out_y(out_y), .colour(colour),
    .valid(valid), .ready(ready), .busy(busy), .frame_done(frame_done)
  );

  lane_scan_renderer #(
    .NUM_LANES(4), .SQUARES(60), .X_OFFSET(5),
    .LANE_COLOURS(12'b010_001_110_100)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .clear_mode(1'b0),
    .lane_seq(lane_seq_b), .out_x(out_x_b), .out_y(out_y_b), .colour(colour_b),
    .valid(valid_b), .ready(ready_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lane_col(input int l);
    case (l)
      0:       return 3'b100;
      1:       return 3'b110;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] exp_col(input logic [77:0] seq, input logic clr,
                                         input int l, input int s);
    if (clr) return 3'b000;
    if (seq[l*26+s]) return lane_col(l);
    if (s == 0) return 3'b111;
    return 3'b000;
  endfunction

  // One frame on the default instance; returns in the DONE cycle.
  task automatic run_a(input logic [77:0] seq, input logic clr, input bit rnd, input bit perturb);
    int cnt, cyc, fd, l, s;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    bit held;
    start = 1'b1; lane_seq = seq; clear_mode = clr; ready = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", valid, 1);
    cnt = 0; cyc = 0; fd = 0; held = 0;
    hx = '0; hy = '0; hc = '0;
    while (cnt < 78 && cyc < 2000) begin
      if (held) begin
        chk("hold_x", out_x, hx);
        chk("hold_y", out_y, hy);
        chk("hold_col", colour, hc);
      end
      chk("valid_in_frame", valid, 1);
      if (frame_done) fd++;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid && ready) begin
        l = cnt / 26; s = cnt % 26;
        chk("req_x", out_x, (1 + 5 * s) % 256);
        chk("req_y", out_y, 53 + 11 * l);
        chk("req_col", colour, exp_col(seq, clr, l, s));
        cnt++;
        held = 0;
      end else begin
        held = 1; hx = out_x; hy = out_y; hc = colour;
      end
      if (perturb && cnt >= 20) begin lane_seq = ~seq; clear_mode = ~clr; end
      start = (perturb && cnt == 30) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0; ready = 1'b1;
    chk("accept_count", cnt, 78);
    chk("early_done", fd, 0);
    chk("done_pulse", frame_done, 1);
    chk("valid_in_done", valid, 0);
    chk("busy_in_done", busy, 1);
  endtask

  initial begin
    int cnt, cyc, fd, s, l;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] ec;
    logic [77:0] pat;

    resetn = 1'b0; start = 1'b0; clear_mode = 1'b0; ready = 1'b0; lane_seq = '0;
    start_b = 1'b0; ready_b = 1'b1; lane_seq_b = '0;
    #3;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_col", colour, 0);
    #10 resetn = 1'b1;
    tick();
    chk("idle_valid", valid, 0);

    // Empty lanes: marker column then black.
    run_a('0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("done_cleared", frame_done, 0);
    chk("busy_cleared", busy, 0);

    // Three notes; a start held only in the DONE cycle must be ignored.
    pat = '0; pat[3] = 1'b1; pat[26+25] = 1'b1; pat[52] = 1'b1;
    run_a(pat, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored_busy", busy, 0);
    tick();
    chk("done_start_ignored_valid", valid, 0);
    chk("done_start_ignored_busy2", busy, 0);

    // Random backpressure.
    pat = 78'h2A_5555_0F0F_3C3C_9999;
    run_a(pat, 1'b0, 1'b1, 1'b0);
    tick();

    // Inputs change and start pulses mid-frame; snapshot must rule.
    run_a(pat, 1'b0, 1'b1, 1'b1);
    fd = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done) fd++;
      chk("no_restart", valid, 0);
    end
    chk("single_done", fd, 1);

    // Erase frame over a full lane pattern.
    run_a('1, 1'b1, 1'b0, 1'b0);
    tick();

    // Reset with the 40th request pending.
    start = 1'b1; lane_seq = '0; clear_mode = 1'b0; ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 39; i++) tick();
    chk("req40_x", out_x, 66);
    chk("req40_y", out_y, 64);
    #2 resetn = 1'b0;
    #1;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_x", out_x, 0);
    chk("abort_y", out_y, 0);
    chk("abort_col", colour, 0);
    #3 resetn = 1'b1;
    tick();
    chk("post_reset_idle", valid, 0);
    chk("post_reset_no_done", frame_done, 0);
    run_a('0, 1'b0, 1'b0, 1'b0);
    tick();

    // Larger geometry: 4 lanes of 60 with x wrap.
    lane_seq_b = '0; lane_seq_b[239] = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cnt = 0; cyc = 0; lx = '0; ly = '0;
    while (cnt < 240 && cyc < 1000) begin
      if (valid_b) begin
        l = cnt / 60; s = cnt % 60;
        ec = (cnt == 239) ? 3'b010 : (s == 0 ? 3'b111 : 3'b000);
        chk("b_x", out_x_b, (1 + 5 * s) % 256);
        chk("b_y", out_y_b, 53 + 11 * l);
        chk("b_col", colour_b, ec);
        lx = out_x_b; ly = out_y_b;
        cnt++;
      end
      tick();
      cyc++;
    end
    chk("b_count", cnt, 240);
    chk("b_last_x", lx, 40);
    chk("b_last_y", ly, 86);
    chk("b_done", frame_done_b, 1);
    tick();
    chk("b_busy_low", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
